// File: rtl/ifu_fetch.sv
// Instruction fetch unit: reads the instruction at pc over an AR/R read port,
// holds it for execute, and pulses pc_wen when execute consumes it.
module ifu_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_wen,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  exec_ready,
  output logic                  mem_arvalid,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic                  mem_arready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  output logic                  mem_rready,
  output logic                  fetch_fault,
  output logic [CNT_WIDTH-1:0]  fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t state;

  // Commit must land on the same edge the PC register loads, so it cannot be registered.
  assign pc_wen = (state == HOLD) && exec_ready;

  // Fetch sequencer; handshake outputs are registered alongside the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      inst        <= '0;
      inst_valid  <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
      mem_rready  <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc[1:0] != 2'b00) begin
            fetch_fault <= 1'b1;
            state       <= HALT;
          end else begin
            mem_araddr  <= pc;
            mem_arvalid <= 1'b1;
            state       <= AR;
          end
        end
        AR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            state       <= R;
          end
        end
        R: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            if (mem_rresp == 2'b00) begin
              inst       <= mem_rdata;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              fetch_fault <= 1'b1;
              state       <= HALT;
            end
          end
        end
        HOLD: begin
          if (exec_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + CNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
